// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: boundary-mode encodings and a
// clamp helper reused by every loadable counter variant.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Limits a load value to the terminal count. Works at 32 bits so that any
  // counter width up to 32 can share it.
  function automatic logic [31:0] clamp(input logic [31:0] value,
                                        input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/updown_load_counter.sv
// Up/down counter with clamped parallel load, programmable terminal value,
// wrap or saturate boundary mode, registered terminal-count pulse and sticky
// overflow flag.
module updown_load_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 2) begin : g_bad_width
    $error("updown_load_counter: WIDTH must be at least 2");
  end
  if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max
    $error("updown_load_counter: MAX_VAL must lie in 1 .. 2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic atBoundary;
  logic [WIDTH-1:0] loadVal;

  assign loadVal    = WIDTH'(clamp(32'(data_in), 32'(MAX_VAL)));
  assign atBoundary = up ? (count_q == MaxVal) : (count_q == '0);

  // tc is only ever produced by an enabled step, so every other branch leaves
  // it at its default of 0.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (rst) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = loadVal;
      ovf_d   = 1'b0;
    end else if (enable) begin
      if (atBoundary) begin
        tc_d = 1'b1;
        if (sat == MODE_SAT) begin
          ovf_d = 1'b1;
        end else begin
          count_d = up ? '0 : MaxVal;
        end
      end else begin
        count_d = up ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
    tc_q    <= tc_d;
    ovf_q   <= ovf_d;
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_load_counter.sv
// Self-checking bench for updown_load_counter at WIDTH=4, MAX_VAL=9: directed
// scenarios plus a randomized run against a modular-arithmetic reference model.
module tb_updown_load_counter;

  localparam int W   = 4;
  localparam int MAX = 9;

  logic         clk = 1'b0;
  logic         rst, load, enable, up, sat;
  logic [W-1:0] dataIn;
  logic [W-1:0] count;
  logic         tc, ovf;

  int nCompared   = 0;
  int nMismatched = 0;

  int mCount;
  bit mTc, mOvf;

  updown_load_counter #(.WIDTH(W), .MAX_VAL(MAX)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(dataIn), .enable(enable),
    .up(up), .sat(sat), .count(count), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: counting is modular over MAX+1 values; boundary is the value
  // about to be left in the current direction.
  function automatic void modelStep(bit r, bit l, int d, bit e, bit u, bit s);
    bit boundary;
    mTc = 0;
    if (r) begin
      mCount = 0;
      mOvf   = 0;
    end else if (l) begin
      mCount = (d > MAX) ? MAX : d;
      mOvf   = 0;
    end else if (e) begin
      boundary = u ? (mCount == MAX) : (mCount == 0);
      mTc = boundary;
      if (boundary && s) mOvf = 1;
      else mCount = u ? (mCount + 1) % (MAX + 1) : (mCount + MAX) % (MAX + 1);
    end
  endfunction

  // Drives one cycle of inputs at the falling edge and returns at the next
  // falling edge, so outputs are sampled half a cycle after the update.
  task automatic applyStimulus(bit r, bit l, int d, bit e, bit u, bit s);
    rst = r; load = l; dataIn = W'(d); enable = e; up = u; sat = s;
    modelStep(r, l, d, e, u, s);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) applyStimulus(1, 1, 5, 1, 1, 0);
    nCompared++;
    if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset: count=%0d tc=%b ovf=%b, required 0 0 0", count, tc, ovf);
    end
  endtask

  task automatic test_wrap_up();
    int expC[4] = '{8, 9, 0, 1};
    bit expT[4] = '{0, 0, 1, 0};
    applyStimulus(0, 1, 7, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 0);
      nCompared++;
      if (count !== W'(expC[i]) || tc !== expT[i] || ovf !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL wrap_up[%0d]: count=%0d tc=%b ovf=%b, required %0d %b 0",
                 i, count, tc, ovf, expC[i], expT[i]);
      end
    end
  endtask

  task automatic test_wrap_down();
    int expC[3] = '{0, 9, 8};
    bit expT[3] = '{0, 1, 0};
    applyStimulus(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0);
      nCompared++;
      if (count !== W'(expC[i]) || tc !== expT[i] || ovf !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL wrap_down[%0d]: count=%0d tc=%b ovf=%b, required %0d %b 0",
                 i, count, tc, ovf, expC[i], expT[i]);
      end
    end
  endtask

  task automatic test_saturate();
    bit expT[4] = '{0, 1, 1, 1};
    applyStimulus(0, 1, 8, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 1);
      nCompared++;
      if (count !== 4'd9 || tc !== expT[i] || ovf !== expT[i]) begin
        nMismatched++;
        $display("[TB] FAIL saturate[%0d]: count=%0d tc=%b ovf=%b, required 9 %b %b",
                 i, count, tc, ovf, expT[i], expT[i]);
      end
    end
    applyStimulus(0, 0, 0, 0, 1, 1);
    nCompared++;
    if (count !== 4'd9 || tc !== 1'b0 || ovf !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL sat_hold: count=%0d tc=%b ovf=%b, required 9 0 1", count, tc, ovf);
    end
    applyStimulus(0, 1, 3, 0, 1, 1);
    nCompared++;
    if (count !== 4'd3 || ovf !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL sat_reload: count=%0d ovf=%b, required 3 0", count, ovf);
    end
  endtask

  task automatic test_clamp_priority();
    applyStimulus(0, 1, 15, 0, 1, 0);
    nCompared++;
    if (count !== 4'd9) begin
      nMismatched++;
      $display("[TB] FAIL clamp: count=%0d, required 9", count);
    end
    applyStimulus(0, 1, 2, 1, 1, 0);
    nCompared++;
    if (count !== 4'd2 || tc !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL load_over_enable: count=%0d tc=%b, required 2 0", count, tc);
    end
  endtask

  task automatic test_direction_switch();
    int expC[4] = '{6, 7, 6, 5};
    bit dir[4]  = '{1, 1, 0, 0};
    applyStimulus(0, 1, 5, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, dir[i], 0);
      nCompared++;
      if (count !== W'(expC[i]) || tc !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL dir_switch[%0d]: count=%0d tc=%b, required %0d 0",
                 i, count, tc, expC[i]);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    applyStimulus(0, 1, 9, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 1, 1);
    applyStimulus(1, 1, 6, 1, 1, 1);
    nCompared++;
    if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid: count=%0d tc=%b ovf=%b, required 0 0 0", count, tc, ovf);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 6) == 0,
                    int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                    1'($urandom), 1'($urandom));
      nCompared++;
      if (count !== W'(mCount) || tc !== mTc || ovf !== mOvf) begin
        nMismatched++;
        $display("[TB] FAIL random[%0d]: count=%0d tc=%b ovf=%b, required %0d %b %b",
                 i, count, tc, ovf, mCount, mTc, mOvf);
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; dataIn = '0; enable = 1'b0; up = 1'b1; sat = 1'b0;
    @(negedge clk);
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_clamp_priority();
    test_direction_switch();
    test_reset_mid_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/updown_load_counter.md
# updown_load_counter

Parametrised synchronous up/down counter with parallel load, programmable terminal value, wrap or saturate mode, a registered terminal-count pulse and a sticky overflow flag. It generalises the team's fixed 4-bit loadable up counter: it serves as a modulo-N or decade counter, a bounded event counter, or a cascadable stage.

## Interface
- WIDTH, 8: counter width in bits; must be at least 2.
- MAX_VAL, 2**WIDTH-1: terminal (maximum) count value; constraint 1 ≤ MAX_VAL ≤ 2**WIDTH-1, checked at elaboration.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  parallel load strobe.
- data_in  in  WIDTH  load value.
- enable  in  1  count enable.
- up  in  1  direction: 1 counts up, 0 counts down.
- sat  in  1  boundary mode: 0 wraps, 1 saturates (values MODE_WRAP/MODE_SAT in the package).
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered.
- ovf  out  1  sticky saturation-overflow flag, registered.

## Operation
- Priority each cycle: rst > load > enable > hold.
- rst: count=0, tc=0, ovf=0. This holds regardless of load or enable.
- load: count = min(data_in, MAX_VAL). An out-of-range value clamps to MAX_VAL. Load also sets tc=0 and ovf=0.
- enable with up=1:
  - count<MAX_VAL: count+1.
  - count==MAX_VAL and sat=0: count wraps to 0.
  - count==MAX_VAL and sat=1: count holds MAX_VAL and ovf sets.
- enable with up=0:
  - count>0: count-1.
  - count==0 and sat=0: count wraps to MAX_VAL.
  - count==0 and sat=1: count holds 0 and ovf sets.
- Boundary event = enable, no load, no rst, and count at the boundary in the current direction (MAX_VAL going up, 0 going down). Each boundary event produces tc=1 for that update. tc=0 otherwise.
- ovf stays set until rst or load. Wrap-mode boundary events do not set ovf.
- up and sat are sampled every cycle. A direction or mode change takes effect on the next enabled edge, with no extra state.
- No enable means count holds, tc=0, and ovf holds.
- Arithmetic is done at WIDTH bits. The next-state value never exceeds MAX_VAL. Unsigned compare only.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- count changes one clock after the qualifying edge (latency 1).
- tc is high in the same cycle count shows the wrapped or held value. It is a single-cycle pulse per boundary event.
- In saturate mode, enable held at the boundary pulses tc on every cycle.
- Cascading: drive the next stage's enable from tc. The upper stage therefore steps one cycle after the lower stage wraps.
- Reset mid-count, including with load=1: count is 0 on the next cycle and no tc is emitted.

## Structure
- Shared package counter_pkg holds:
  - constants MODE_WRAP=1'b0 and MODE_SAT=1'b1;
  - a function clamp(value, max) shared by future counter variants.
- Single module with no sub-module. Boundary detect and next-state are small combinational logic feeding three registers.

## Test plan
Directed tests use WIDTH=4, MAX_VAL=9.
- Reset: assert rst for 2 cycles with load=1 and data_in=5 -> count=0, tc=0, ovf=0.
- Wrap up: load 7, then enable with up=1 and sat=0 for 4 cycles -> count 8, 9, 0, 1. tc=1 only in the cycle count=0. ovf=0.
- Wrap down: load 1, then enable with up=0 and sat=0 for 3 cycles -> count 0, 9, 8. tc=1 only in the cycle count=9.
- Saturate: load 8, then enable with up=1 and sat=1 for 4 cycles -> count 9, 9, 9, 9. tc=0,1,1,1 and ovf=0,1,1,1. Then load 3 -> count=3, ovf=0.
- Clamp and priority: load with data_in=15 -> count=9. Then load=1 and enable=1 together with data_in=2 -> count=2 and tc=0.
- Direction switch: load 5, then enable with up=1, 1, 0, 0 -> count 6, 7, 6, 5. No tc.
